// File: rtl/ts4231_pkg.sv
// Shared definitions for the TS4231 two-wire stream (generator and receiver side).
// Holds state encodings, default frame timing and small elaboration helpers.
package ts4231_pkg;

  localparam int MAX_FRAME_BITS = 64;

  // Default timing at 50 MHz; DEF_LEAD_CLKS is also the receiver's 1 us lead threshold.
  localparam int DEF_LEAD_CLKS = 50;
  localparam int DEF_BIT_CLKS  = 8;
  localparam int DEF_GAP_CLKS  = 100;

  localparam int ST_W = 3;
  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LEAD  = 3'd1;
  localparam state_t ST_START = 3'd2;
  localparam state_t ST_DATA  = 3'd3;
  localparam state_t ST_GAP   = 3'd4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ts4231_stream_tx_if.sv
// Frame request handshake between a frame source and the TS4231 stream generator.
interface ts4231_stream_tx_if #(
  parameter int MAX_BITS = 64,
  parameter int LEN_W    = 7
);
  logic                tx_valid;
  logic                tx_ready;
  logic [MAX_BITS-1:0] tx_payload;
  logic [LEN_W-1:0]    tx_len;

  modport master (output tx_valid, tx_payload, tx_len, input tx_ready);
  modport slave  (input tx_valid, tx_payload, tx_len, output tx_ready);
endinterface

// File: rtl/ts4231_bit_timer.sv
// Loadable down-counter shared by all frame phases; tc_o flags the last cycle
// of the current phase, tc_nxt_o flags that the next cycle will be the last.
module ts4231_bit_timer #(
  parameter int W = 7
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o,
  output logic         tc_nxt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)             cnt_d = load_val_i;
    else if (cnt_q != '0)   cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc_o     = (cnt_q == '0);
  assign tc_nxt_o = (cnt_d == '0);

endmodule

// File: rtl/ts4231_stream_tx.sv
// TS4231-style frame generator: envelope low for lead-in, start bit and payload,
// then a timed high gap. Every output is a register fed from next-state logic.
module ts4231_stream_tx
  import ts4231_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int MAX_BITS    = MAX_FRAME_BITS,
  parameter int LEN_W       = 7,
  parameter int BIT_CLKS    = DEF_BIT_CLKS,
  parameter int LEAD_CLKS   = DEF_LEAD_CLKS,
  parameter int GAP_CLKS    = DEF_GAP_CLKS
)(
  input  logic                     clk,
  input  logic                     rst_n,
  ts4231_stream_tx_if.slave        tx,
  input  logic                     abort_i,
  output logic                     n_is_valid_o,
  output logic                     bit_datstream_o,
  output logic                     frame_done_o,
  output logic [7:0]               frame_cnt_o
);

  localparam int TW = $clog2(max3(LEAD_CLKS, BIT_CLKS, GAP_CLKS) + 1);
  localparam logic [TW-1:0]    LEAD_LD = TW'(LEAD_CLKS - 1);
  localparam logic [TW-1:0]    BIT_LD  = TW'(BIT_CLKS - 1);
  localparam logic [TW-1:0]    GAP_LD  = TW'(GAP_CLKS - 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_BITS);

  if (CLK_FREQ_HZ <= 0) begin : g_chk_clk
    $error("CLK_FREQ_HZ must be positive");
  end
  if ((1 << LEN_W) <= MAX_BITS) begin : g_chk_len
    $error("LEN_W too narrow for MAX_BITS");
  end
  if (BIT_CLKS < 1 || LEAD_CLKS < 1 || GAP_CLKS < 1) begin : g_chk_tim
    $error("timing parameters must be at least 1");
  end

  state_t              state_q, state_d;
  logic [MAX_BITS-1:0] sr_q, sr_d;
  logic [LEN_W-1:0]    left_q, left_d;
  logic                ready_q, ready_d;
  logic                n_vld_q, n_vld_d;
  logic                bit_q, bit_d;
  logic                done_q, done_d;
  logic [7:0]          fcnt_q;

  logic                tmr_ld, tmr_tc, tmr_tc_nxt, to_gap, accept;
  logic [TW-1:0]       tmr_val;
  logic [LEN_W-1:0]    len_clamp;

  ts4231_bit_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_ld),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc),
    .tc_nxt_o   (tmr_tc_nxt)
  );

  assign accept    = tx.tx_valid && ready_q;
  assign len_clamp = (tx.tx_len > LEN_MAX) ? LEN_MAX : tx.tx_len;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    left_d  = left_q;
    tmr_ld  = 1'b0;
    tmr_val = '0;
    to_gap  = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d = ST_LEAD;
        sr_d    = tx.tx_payload;
        left_d  = len_clamp;
        tmr_ld  = 1'b1;
        tmr_val = LEAD_LD;
      end
      ST_LEAD: begin
        if (abort_i) to_gap = 1'b1;
        else if (tmr_tc) begin
          state_d = ST_START;
          tmr_ld  = 1'b1;
          tmr_val = BIT_LD;
        end
      end
      ST_START: begin
        if (abort_i || (tmr_tc && left_q == '0)) to_gap = 1'b1;
        else if (tmr_tc) begin
          state_d = ST_DATA;
          tmr_ld  = 1'b1;
          tmr_val = BIT_LD;
        end
      end
      ST_DATA: begin
        if (abort_i) to_gap = 1'b1;
        else if (tmr_tc) begin
          sr_d   = {sr_q[MAX_BITS-2:0], 1'b0};
          left_d = left_q - LEN_W'(1);
          if (left_q == LEN_W'(1)) to_gap = 1'b1;
          else begin
            tmr_ld  = 1'b1;
            tmr_val = BIT_LD;
          end
        end
      end
      ST_GAP:  if (tmr_tc) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Every route into the gap, aborts included, times the full gap.
    if (to_gap) begin
      state_d = ST_GAP;
      tmr_ld  = 1'b1;
      tmr_val = GAP_LD;
    end
  end

  // Outputs are decoded from next state so they line up with the state register.
  always_comb begin
    ready_d = (state_d == ST_IDLE);
    n_vld_d = !(state_d inside {ST_LEAD, ST_START, ST_DATA});
    bit_d   = (state_d == ST_START) || ((state_d == ST_DATA) && sr_d[MAX_BITS-1]);
    done_d  = (state_d == ST_GAP) && tmr_tc_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      left_q  <= '0;
      ready_q <= 1'b1;
      n_vld_q <= 1'b1;
      bit_q   <= 1'b0;
      done_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      left_q  <= left_d;
      ready_q <= ready_d;
      n_vld_q <= n_vld_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
      if (done_d) fcnt_q <= fcnt_q + 8'd1;
    end
  end

  assign tx.tx_ready     = ready_q;
  assign n_is_valid_o    = n_vld_q;
  assign bit_datstream_o = bit_q;
  assign frame_done_o    = done_q;
  assign frame_cnt_o     = fcnt_q;

endmodule

// File: tb/tb_ts4231_stream_tx.sv
// Directed bench for ts4231_stream_tx: frame table plus reset and back-to-back sequences.
module tb_ts4231_stream_tx;
  localparam int MB = 16, LW = 5, BC = 4, LC = 10, GC = 6;

  logic       clk = 1'b0, rst_n = 1'b1, abort_i = 1'b0;
  logic       n_is_valid_o, bit_datstream_o, frame_done_o;
  logic [7:0] frame_cnt_o;

  ts4231_stream_tx_if #(.MAX_BITS(MB), .LEN_W(LW)) txif ();

  ts4231_stream_tx #(
    .CLK_FREQ_HZ(50_000_000), .MAX_BITS(MB), .LEN_W(LW),
    .BIT_CLKS(BC), .LEAD_CLKS(LC), .GAP_CLKS(GC)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tx              (txif.slave),
    .abort_i         (abort_i),
    .n_is_valid_o    (n_is_valid_o),
    .bit_datstream_o (bit_datstream_o),
    .frame_done_o    (frame_done_o),
    .frame_cnt_o     (frame_cnt_o)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, exp_cnt = 0;

  typedef struct {
    logic [MB-1:0] payload;
    logic [LW-1:0] len;
    int            abort_at;   // low-cycle index where abort is raised, -1 for none
    bit            hold_valid; // keep tx_valid high through the frame
    bit            abort_acc;  // raise abort together with tx_valid in IDLE
    int            exp_low;    // envelope-low cycles
    logic [MB:0]   exp_bits;   // start bit + sent payload bits, right-aligned
    int            exp_nbits;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic exp_bit(input vec_t v, input int k);
    int idx;
    if (k < LC) return 1'b0;
    idx = (k - LC) / BC;
    if (idx >= v.exp_nbits) return 1'b0;
    return v.exp_bits[v.exp_nbits-1-idx];
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int k, g, errs;
    bit done;
    @(negedge clk);
    check({tag, "_ready"}, txif.tx_ready, 1);
    txif.tx_valid   = 1'b1;
    txif.tx_payload = v.payload;
    txif.tx_len     = v.len;
    abort_i         = v.abort_acc;
    @(negedge clk);
    txif.tx_valid = v.hold_valid;
    abort_i       = 1'b0;
    k = 0; errs = 0;
    while (n_is_valid_o == 1'b0 && k < 400) begin
      if (bit_datstream_o !== exp_bit(v, k)) errs++;
      if (txif.tx_ready !== 1'b0) errs++;
      if (k == v.abort_at) abort_i = 1'b1;
      k++;
      @(negedge clk);
      abort_i = 1'b0;
    end
    txif.tx_valid = 1'b0;
    check({tag, "_low_cycles"}, k, v.exp_low);
    check({tag, "_bits"}, errs, 0);
    g = 0; done = 1'b0; errs = 0;
    while (!done && g < 50) begin
      g++;
      if (bit_datstream_o !== 1'b0 || n_is_valid_o !== 1'b1) errs++;
      if (frame_done_o) done = 1'b1;
      else @(negedge clk);
    end
    exp_cnt = (exp_cnt + 1) % 256;
    check({tag, "_gap_len"}, g, GC);
    check({tag, "_gap_lines"}, errs, 0);
    check({tag, "_cnt"}, frame_cnt_o, exp_cnt);
    @(negedge clk);
    check({tag, "_ready_after"}, txif.tx_ready, 1);
    check({tag, "_done_single"}, frame_done_o, 0);
    errs = 0;
    repeat (3) begin
      @(negedge clk);
      if (n_is_valid_o !== 1'b1) errs++;
    end
    check({tag, "_no_queue"}, errs, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nd, cyc, last, sp_bad;
    vecs[0] = '{16'hA000, 5'd3,  -1, 1'b0, 1'b0, 26, 17'h0000D, 4};
    vecs[1] = '{16'h1234, 5'd0,  -1, 1'b0, 1'b1, 14, 17'h00001, 1};
    vecs[2] = '{16'hFFFF, 5'd20, -1, 1'b0, 1'b0, 78, 17'h1FFFF, 17};
    vecs[3] = '{16'h8001, 5'd16, -1, 1'b1, 1'b0, 78, 17'h18001, 17};
    vecs[4] = '{16'h5A5A, 5'd8,  -1, 1'b0, 1'b0, 46, 17'h0015A, 9};
    vecs[5] = '{16'hA000, 5'd3,  19, 1'b1, 1'b0, 20, 17'h0000D, 4};

    txif.tx_valid = 1'b0; txif.tx_payload = '0; txif.tx_len = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", txif.tx_ready, 1);
    check("rst_nvalid", n_is_valid_o, 1);
    check("rst_bit", bit_datstream_o, 0);
    check("rst_done", frame_done_o, 0);
    check("rst_cnt", frame_cnt_o, 0);
    rst_n = 1'b1;

    abort_i = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_abort_nvalid", n_is_valid_o, 1);
    check("idle_abort_ready", txif.tx_ready, 1);
    abort_i = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset in the middle of the payload, without a clock edge.
    @(negedge clk);
    txif.tx_valid = 1'b1; txif.tx_payload = 16'hFFFF; txif.tx_len = 5'd16;
    @(negedge clk);
    txif.tx_valid = 1'b0;
    repeat (30) @(negedge clk);
    check("mid_data_nvalid", n_is_valid_o, 0);
    check("mid_data_bit", bit_datstream_o, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_nvalid", n_is_valid_o, 1);
    check("async_rst_bit", bit_datstream_o, 0);
    check("async_rst_ready", txif.tx_ready, 1);
    check("async_rst_cnt", frame_cnt_o, 0);
    exp_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0], "post_rst");

    // 256 back-to-back empty frames from count 0.
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    txif.tx_valid = 1'b1; txif.tx_payload = '0; txif.tx_len = '0;
    nd = 0; cyc = 0; last = 0; sp_bad = 0;
    while (nd < 256 && cyc < 10000) begin
      @(negedge clk);
      cyc++;
      if (frame_done_o) begin
        nd++;
        if (nd > 1 && (cyc - last) != (LC + BC + GC + 1)) sp_bad++;
        last = cyc;
        if (nd == 255) check("b2b_cnt255", frame_cnt_o, 255);
        if (nd == 256) begin
          check("b2b_wrap", frame_cnt_o, 0);
          txif.tx_valid = 1'b0;
        end
      end
    end
    check("b2b_frames", nd, 256);
    check("b2b_spacing", sp_bad, 0);
    repeat (3) @(negedge clk);
    check("b2b_idle_nvalid", n_is_valid_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
